// File: rtl/dkong_dma_mc.sv
// Multi-channel sprite/block DMA: fixed-priority channel pick, HRQ/HLDA bus handshake,
// four-phase byte copy (present source, latch data, write, advance destination).
module dkong_dma_mc #(
  parameter int CH   = 2,
  parameter int AW   = 10,
  parameter int DW   = 8,
  parameter int LENW = 10,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              I_CLK,
  input  logic              I_RSTn,
  input  logic              I_CLK_EN,
  input  logic [CH-1:0]     I_DMA_TRIG,
  input  logic [CH*AW-1:0]  I_DMA_SRC,
  input  logic [CH*AW-1:0]  I_DMA_DST,
  input  logic [CH*LENW-1:0] I_DMA_LEN,
  input  logic [DW-1:0]     I_DMA_DS,
  input  logic              I_HLDA,
  output logic              O_HRQ,
  output logic [AW-1:0]     O_DMA_AS,
  output logic [AW-1:0]     O_DMA_AD,
  output logic [DW-1:0]     O_DMA_DD,
  output logic              O_DMA_CES,
  output logic              O_DMA_CED,
  output logic              O_DMA_WE,
  output logic [CHW-1:0]    O_DMA_CH,
  output logic              O_DMA_BUSY,
  output logic [CH-1:0]     O_DMA_DONE
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  state_t          state, next_state;
  logic [CH-1:0]   prev_trig, pend, rise, clr;
  logic [AW-1:0]   as_q, ad_q;
  logic [DW-1:0]   dd_q;
  logic [LENW-1:0] rem;
  logic [CHW-1:0]  ch_q, sel;
  logic            sel_valid;
  logic [1:0]      phase;
  logic            bus_q;
  logic [CH-1:0]   done_q;
  logic            load, advance, last, we;

  assign rise = I_DMA_TRIG & ~prev_trig;

  // Descending scan so the lowest pending index is the last one written.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int unsigned n = CH; n > 0; n--) begin
      if (pend[n-1]) begin
        sel       = CHW'(n - 1);
        sel_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn)       state <= IDLE;
    else if (I_CLK_EN) state <= next_state;
  end

  // RELEASE shares IDLE's pick, so a queued channel reloads after a one-cycle bus gap.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load) next_state = REQ;
      REQ:     if (I_HLDA) next_state = XFER;
      XFER:    if (last) next_state = RELEASE;
      RELEASE: next_state = load ? REQ : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    advance = 1'b0;
    last    = 1'b0;
    we      = 1'b0;
    clr     = '0;
    case (state)
      IDLE, RELEASE: load = sel_valid;
      XFER: begin
        advance = I_HLDA;
        we      = (phase == 2'd2);
        last    = I_HLDA && (phase == 2'd3) && (rem == '0);
      end
      default: ;
    endcase
    if (load) clr = CH'(1) << sel;
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      prev_trig <= '0;
      pend      <= '0;
      as_q      <= '0;
      ad_q      <= '0;
      dd_q      <= '0;
      rem       <= '0;
      ch_q      <= '0;
      phase     <= '0;
      bus_q     <= 1'b0;
      done_q    <= '0;
    end else if (I_CLK_EN) begin
      prev_trig <= I_DMA_TRIG;
      pend      <= (pend & ~clr) | rise;
      done_q    <= '0;
      if (load) begin
        as_q  <= I_DMA_SRC[int'(sel)*AW +: AW];
        ad_q  <= I_DMA_DST[int'(sel)*AW +: AW];
        rem   <= I_DMA_LEN[int'(sel)*LENW +: LENW];
        ch_q  <= sel;
        phase <= '0;
        bus_q <= 1'b1;
      end else if (advance) begin
        phase <= phase + 2'd1;
        case (phase)
          2'd1: dd_q <= I_DMA_DS;
          2'd2: as_q <= as_q + AW'(1);
          2'd3: begin
            ad_q <= ad_q + AW'(1);
            if (rem == '0) begin
              done_q[ch_q] <= 1'b1;
              bus_q        <= 1'b0;
            end else begin
              rem <= rem - LENW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign O_HRQ      = bus_q;
  assign O_DMA_CES  = bus_q;
  assign O_DMA_CED  = bus_q;
  assign O_DMA_BUSY = bus_q;
  assign O_DMA_AS   = as_q;
  assign O_DMA_AD   = ad_q;
  assign O_DMA_DD   = dd_q;
  assign O_DMA_WE   = we;
  assign O_DMA_CH   = ch_q;
  assign O_DMA_DONE = done_q;

endmodule

// File: tb/tb_dkong_dma_mc.sv
// Bench for dkong_dma_mc: source RAM model, write-log monitor and a byte-copy reference queue.
module tb_dkong_dma_mc;
  localparam int CH = 2, AW = 10, DW = 8, LENW = 10, CHW = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic en_val = 1'b1, en_toggle = 1'b0, tog = 1'b0, clk_en;
  logic hlda_val = 1'b1, hlda_rand = 1'b0, rnd_bit = 1'b1, hlda;
  logic [CH-1:0]      trig = '0;
  logic [CH*AW-1:0]   src = '0, dst = '0;
  logic [CH*LENW-1:0] len = '0;
  logic [DW-1:0]      ds;
  logic               hrq, ces, ced, we, busy;
  logic [AW-1:0]      as_o, ad_o;
  logic [DW-1:0]      dd_o;
  logic [CHW-1:0]     ch_o;
  logic [CH-1:0]      done;

  logic [DW-1:0] src_mem [1024];

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [AW-1:0]  ad;
    logic [DW-1:0]  dd;
  } wr_t;
  wr_t wr_q[$], exp_q[$];
  int  done_cnt[CH];
  int  viol = 0;
  int  passed = 0, total = 0;
  logic we_prev = 1'b0;
  logic [CH-1:0] done_prev = '0;

  dkong_dma_mc #(.CH(CH), .AW(AW), .DW(DW), .LENW(LENW)) dut (
    .I_CLK(clk), .I_RSTn(rst_n), .I_CLK_EN(clk_en), .I_DMA_TRIG(trig),
    .I_DMA_SRC(src), .I_DMA_DST(dst), .I_DMA_LEN(len), .I_DMA_DS(ds),
    .I_HLDA(hlda), .O_HRQ(hrq), .O_DMA_AS(as_o), .O_DMA_AD(ad_o),
    .O_DMA_DD(dd_o), .O_DMA_CES(ces), .O_DMA_CED(ced), .O_DMA_WE(we),
    .O_DMA_CH(ch_o), .O_DMA_BUSY(busy), .O_DMA_DONE(done)
  );

  assign ds     = src_mem[as_o];
  assign clk_en = en_toggle ? tog : en_val;
  assign hlda   = hlda_rand ? rnd_bit : hlda_val;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tog     <= ~tog;
    rnd_bit <= ($urandom_range(0, 3) != 0);
  end

  // Write log and bus-invariant watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      we_prev   = 1'b0;
      done_prev = '0;
    end else begin
      if (we && !we_prev) wr_q.push_back('{ch_o, ad_o, dd_o});
      for (int n = 0; n < CH; n++)
        if (done[n] && !done_prev[n]) done_cnt[n]++;
      if (we && !(hrq && ces && ced && busy)) viol++;
      if ((done != '0) && (hrq || we)) viol++;
      we_prev   = we;
      done_prev = done;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int s, input int d, input int l);
    src[c*AW +: AW]     = AW'(s);
    dst[c*AW +: AW]     = AW'(d);
    len[c*LENW +: LENW] = LENW'(l);
  endtask

  function automatic void expect_xfer(input int c, input int s, input int d, input int l);
    for (int i = 0; i <= l; i++) begin
      wr_t e;
      e.ch = CHW'(c);
      e.ad = AW'(d + i);
      e.dd = src_mem[AW'(s + i)];
      exp_q.push_back(e);
    end
  endfunction

  function automatic int count_bad();
    int b = 0;
    if (wr_q.size() != exp_q.size()) b++;
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) b++;
    return b;
  endfunction

  task automatic pulse(input logic [CH-1:0] mask);
    trig = mask;
    tick();
    trig = '0;
  endtask

  task automatic wait_done(input int c, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt[c] >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({hrq, ces, ced, we, busy, done, ch_o} !== '0)
      $display("FAIL reset_ctrl: got %b want 0", {hrq, ces, ced, we, busy, done, ch_o});
    else passed++;
    total++;
    if ({as_o, ad_o, dd_o} !== '0)
      $display("FAIL reset_data: got %h want 0", {as_o, ad_o, dd_o});
    else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_block();
    bit ok;
    int d0 = done_cnt[0];
    wr_q.delete(); exp_q.delete();
    set_ch(0, 'h100, 0, 'h17F);
    expect_xfer(0, 'h100, 0, 'h17F);
    trig = 2'b01;
    tick();
    total++;
    if (hrq !== 1'b0) $display("FAIL latency_early: hrq got %b want 0", hrq); else passed++;
    trig = '0;
    tick();
    total++;
    if ({hrq, busy, ch_o} !== 3'b110)
      $display("FAIL latency_load: hrq/busy/ch got %b want 110", {hrq, busy, ch_o});
    else passed++;
    wait_done(0, d0 + 1, 2500, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL full_timeout: done got %0d want %0d", done_cnt[0], d0 + 1); else passed++;
    repeat (4) tick();
    total++;
    if (wr_q.size() !== 384) $display("FAIL full_count: got %0d want 384", wr_q.size()); else passed++;
    total++;
    if (count_bad() !== 0) $display("FAIL full_data: got %0d bad entries want 0", count_bad()); else passed++;
    total++;
    if (done_cnt[0] !== d0 + 1) $display("FAIL full_done: got %0d want %0d", done_cnt[0], d0 + 1); else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    int d0 = done_cnt[0];
    int n;
    wr_q.delete(); exp_q.delete();
    set_ch(0, 'h3FF, 'h3FF, 0);
    expect_xfer(0, 'h3FF, 'h3FF, 0);
    pulse(2'b01);
    n = 0;
    while (!we && n < 50) begin tick(); n++; end
    total++;
    if (as_o !== 10'h3FF) $display("FAIL wrap_as_ph2: got %h want 3ff", as_o); else passed++;
    tick();
    total++;
    if (as_o !== 10'h000) $display("FAIL wrap_as: got %h want 000", as_o); else passed++;
    wait_done(0, d0 + 1, 50, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL wrap_timeout: done got %0d want %0d", done_cnt[0], d0 + 1); else passed++;
    total++;
    if (ad_o !== 10'h000) $display("FAIL wrap_ad: got %h want 000", ad_o); else passed++;
    tick();
    total++;
    if (count_bad() !== 0) $display("FAIL wrap_data: got %0d bad entries want 0", count_bad()); else passed++;
  endtask

  task automatic test_simultaneous();
    bit ok0, ok1;
    int gap = 0;
    int s0 = $urandom_range(0, 1023), d0 = $urandom_range(0, 1023), l0 = $urandom_range(3, 20);
    int s1 = $urandom_range(0, 1023), d1 = $urandom_range(0, 1023), l1 = $urandom_range(3, 20);
    int c0 = done_cnt[0], c1 = done_cnt[1];
    wr_q.delete(); exp_q.delete();
    set_ch(0, s0, d0, l0);
    set_ch(1, s1, d1, l1);
    expect_xfer(0, s0, d0, l0);
    expect_xfer(1, s1, d1, l1);
    pulse(2'b11);
    wait_done(0, c0 + 1, 400, ok0);
    while (!hrq && gap < 10) begin gap++; tick(); end
    total++;
    if (gap !== 1) $display("FAIL prio_gap: hrq low for %0d cycles want 1", gap); else passed++;
    total++;
    if (ch_o !== 1'b1) $display("FAIL prio_ch: got %0d want 1", ch_o); else passed++;
    wait_done(1, c1 + 1, 400, ok1);
    tick();
    total++;
    if ({ok0, ok1} !== 2'b11) $display("FAIL prio_timeout: got %b want 11", {ok0, ok1}); else passed++;
    total++;
    if (count_bad() !== 0) $display("FAIL prio_order: got %0d bad entries want 0", count_bad()); else passed++;
  endtask

  task automatic test_hlda_stall();
    bit ok;
    int n = 0;
    int s = $urandom_range(0, 1023), d = $urandom_range(0, 1023);
    int c0 = done_cnt[0];
    logic [AW-1:0] s_as, s_ad;
    logic [DW-1:0] s_dd;
    wr_q.delete(); exp_q.delete();
    set_ch(0, s, d, 7);
    expect_xfer(0, s, d, 7);
    pulse(2'b01);
    while (!(wr_q.size() == 3 && !we) && n < 100) begin tick(); n++; end
    tick();
    tick();
    hlda_val = 1'b0;
    s_as = as_o; s_ad = ad_o; s_dd = dd_o;
    total++;
    if (s_as !== AW'(s + 3)) $display("FAIL stall_as: got %h want %h", s_as, AW'(s + 3)); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({as_o, ad_o, dd_o, we, hrq} !== {s_as, s_ad, s_dd, 1'b0, 1'b1})
        $display("FAIL stall_hold%0d: got %h want %h", i, {as_o, ad_o, dd_o, we, hrq},
                 {s_as, s_ad, s_dd, 1'b0, 1'b1});
      else passed++;
    end
    hlda_val = 1'b1;
    tick();
    total++;
    if ({we, dd_o} !== {1'b1, src_mem[AW'(s + 3)]})
      $display("FAIL stall_resume: got %h want %h", {we, dd_o}, {1'b1, src_mem[AW'(s + 3)]});
    else passed++;
    wait_done(0, c0 + 1, 200, ok);
    tick();
    total++;
    if (ok !== 1'b1) $display("FAIL stall_timeout: done got %0d want %0d", done_cnt[0], c0 + 1); else passed++;
    total++;
    if (count_bad() !== 0) $display("FAIL stall_data: got %0d bad entries want 0", count_bad()); else passed++;
  endtask

  task automatic test_clk_en();
    bit ok;
    int n = 0;
    int s = $urandom_range(0, 1023), d = $urandom_range(0, 1023);
    int c0 = done_cnt[0];
    en_toggle = 1'b1;
    wr_q.delete(); exp_q.delete();
    set_ch(0, s, d, 5);
    expect_xfer(0, s, d, 5);
    while (clk_en !== 1'b1 && n < 4) begin tick(); n++; end
    trig = 2'b01;
    tick();
    tick();
    trig = '0;
    wait_done(0, c0 + 1, 300, ok);
    repeat (6) tick();
    total++;
    if (ok !== 1'b1) $display("FAIL clken_timeout: done got %0d want %0d", done_cnt[0], c0 + 1); else passed++;
    total++;
    if (count_bad() !== 0) $display("FAIL clken_data: got %0d bad entries want 0", count_bad()); else passed++;
    total++;
    if (done_cnt[0] !== c0 + 1) $display("FAIL clken_single: got %0d want %0d", done_cnt[0], c0 + 1); else passed++;
    wr_q.delete();
    trig = 2'b01;
    wait_done(0, c0 + 2, 300, ok);
    repeat (120) tick();
    trig = '0;
    total++;
    if (done_cnt[0] !== c0 + 2) $display("FAIL held_trig_done: got %0d want %0d", done_cnt[0], c0 + 2); else passed++;
    total++;
    if (wr_q.size() !== 6) $display("FAIL held_trig_bytes: got %0d want 6", wr_q.size()); else passed++;
    en_toggle = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    int c0 = done_cnt[0];
    int s = $urandom_range(0, 1023), d = $urandom_range(0, 1023);
    wr_q.delete(); exp_q.delete();
    set_ch(0, s, d, 100);
    pulse(2'b01);
    while (wr_q.size() < 10 && n < 200) begin tick(); n++; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({hrq, ces, ced, we, busy, done, ch_o, as_o, ad_o, dd_o} !== '0)
      $display("FAIL rstmid_outputs: got %h want 0", {hrq, ces, ced, we, busy, done, ch_o, as_o, ad_o, dd_o});
    else passed++;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    total++;
    if (done_cnt[0] !== c0) $display("FAIL rstmid_nodone: got %0d want %0d", done_cnt[0], c0); else passed++;
    wr_q.delete();
    set_ch(0, d, s, 4);
    expect_xfer(0, d, s, 4);
    pulse(2'b01);
    wait_done(0, c0 + 1, 200, ok);
    tick();
    total++;
    if (ok !== 1'b1) $display("FAIL rstmid_retrig: done got %0d want %0d", done_cnt[0], c0 + 1); else passed++;
    total++;
    if (count_bad() !== 0) $display("FAIL rstmid_data: got %0d bad entries want 0", count_bad()); else passed++;
  endtask

  task automatic test_random();
    bit ok;
    hlda_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int c = $urandom_range(0, CH - 1);
      int s = $urandom_range(0, 1023), d = $urandom_range(0, 1023), l = $urandom_range(0, 15);
      int cnt = done_cnt[c];
      wr_q.delete(); exp_q.delete();
      set_ch(c, s, d, l);
      expect_xfer(c, s, d, l);
      pulse(CH'(1) << c);
      wait_done(c, cnt + 1, 1000, ok);
      tick();
      total++;
      if (ok !== 1'b1) $display("FAIL rand%0d_timeout: done got %0d want %0d", k, done_cnt[c], cnt + 1); else passed++;
      total++;
      if (count_bad() !== 0) $display("FAIL rand%0d_data: got %0d bad entries want 0", k, count_bad()); else passed++;
    end
    hlda_rand = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) src_mem[i] = DW'($urandom);
    for (int n = 0; n < CH; n++) done_cnt[n] = 0;
    test_reset();
    test_full_block();
    test_wrap();
    test_simultaneous();
    test_hlda_stall();
    test_clk_en();
    test_reset_mid();
    test_random();
    total++;
    if (viol !== 0) $display("FAIL bus_invariants: got %0d violations want 0", viol); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
